// File: rtl/data_recv.sv
// AXI-stream receive checker: hunts for frame sync on tlast, then checks an
// incrementing 32-bit pattern replicated over 8 lanes. Optional error capture
// registers are built only when DATA_RECV_CAPTURE_EN is defined.

module data_recv_lane #(
  parameter int VEC_W = 32
) (
  input  logic [VEC_W-1:0] lane_data,
  input  logic [VEC_W-1:0] exp_val,
  output logic             mis
);
  assign mis = (lane_data != exp_val);
endmodule

module data_recv #(
  parameter int FRAME_BEATS = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  input  logic                 axis_tvalid,
  input  logic [255:0]         axis_tdata,
  input  logic [31:0]          axis_tkeep,
  input  logic                 axis_tlast,
  input  logic                 clr_cnt,
  output logic                 lock,
  output logic                 beat_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          frame_cnt
`ifdef DATA_RECV_CAPTURE_EN
  ,
  output logic [255:0]         cap_data,
  output logic [31:0]          cap_expect,
  output logic                 cap_valid
`endif
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 32;
  localparam int IDX_W     = $clog2(FRAME_BEATS);

  typedef enum logic {HUNT, CHECK} state_t;

  state_t                            state, state_nxt;
  logic [VEC_W-1:0]                  exp_val;
  logic [IDX_W-1:0]                  beat_idx;
  logic [3:0]                        consec;
  logic [NUM_LANES-1:0]              lane_mis;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lanes;
  logic                              last_exp, beat_bad, chk_beat, is_err, loss, sync;
  logic [4:0]                        consec_inc;

  assign lanes = axis_tdata;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    data_recv_lane #(.VEC_W(VEC_W)) u_lane (
      .lane_data (lanes[k]),
      .exp_val   (exp_val),
      .mis       (lane_mis[k])
    );
  end

  always_comb begin
    last_exp   = (beat_idx == IDX_W'(FRAME_BEATS - 1));
    beat_bad   = (|lane_mis) | (axis_tkeep != 32'hFFFF_FFFF) | (axis_tlast != last_exp);
    chk_beat   = axis_tvalid && (state == CHECK);
    sync       = axis_tvalid && axis_tlast && (state == HUNT);
    is_err     = chk_beat && beat_bad;
    consec_inc = {1'b0, consec} + 5'd1;
    loss       = is_err && (consec_inc >= 5'(LOSS_THRESH));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync) state_nxt = CHECK;
      CHECK:   if (loss) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) state <= HUNT;
    else               state <= state_nxt;
  end

  assign lock = (state == CHECK);

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      exp_val    <= '0;
      beat_idx   <= '0;
      consec     <= '0;
      beat_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      beat_err <= is_err;
      if (sync) begin
        exp_val  <= lanes[0] + 32'd1;
        beat_idx <= '0;
        consec   <= '0;
      end else if (chk_beat) begin
        // exp free-runs; a missing beat is detected, never resynced to
        exp_val  <= exp_val + 32'd1;
        beat_idx <= (axis_tlast || last_exp) ? '0 : beat_idx + 1'b1;
        consec   <= (!beat_bad || loss) ? 4'd0 : consec_inc[3:0];
      end
      if (clr_cnt) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
        frame_cnt  <= '0;
      end else begin
        if (is_err) err_sticky <= 1'b1;
        if (is_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        if (chk_beat && axis_tlast) frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

`ifdef DATA_RECV_CAPTURE_EN
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn || clr_cnt) begin
      cap_data   <= '0;
      cap_expect <= '0;
      cap_valid  <= 1'b0;
    end else if (is_err && !cap_valid) begin
      cap_data   <= axis_tdata;
      cap_expect <= exp_val;
      cap_valid  <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/data_recv.md
DATA_RECV -- requirements
Module: data_recv

Interface
REQ-001 SHALL have parameter FRAME_BEATS, default 16, beats per frame (2..1024).
REQ-002 SHALL have parameter LOSS_THRESH, default 4, consecutive errored beats that drop lock (1..15).
REQ-003 SHALL have parameter ERR_CNT_W, default 16, error counter width.
REQ-004 SHALL have port axis_aclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port axis_aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port axis_tvalid  input  1  receive beat valid; there is no tready, and every valid beat SHALL be consumed.
REQ-007 SHALL have port axis_tdata  input  256  beat data; lane k = bits [32k+31:32k], k = 0..7.
REQ-008 SHALL have port axis_tkeep  input  32  byte enables.
REQ-009 SHALL have port axis_tlast  input  1  last beat of frame.
REQ-010 SHALL have port clr_cnt  input  1  synchronous clear of counters and sticky flag.
REQ-011 SHALL have port lock  output  1  1 while in CHECK state.
REQ-012 SHALL have port beat_err  output  1  one-cycle pulse per errored beat.
REQ-013 SHALL have port err_sticky  output  1  set on any error; cleared only by reset or clr_cnt.
REQ-014 SHALL have port err_cnt  output  ERR_CNT_W  errored beats, saturating at all-ones.
REQ-015 SHALL have port frame_cnt  output  32  frames completed in CHECK; wraps modulo 2^32.

Function
REQ-016 Expected pattern per beat: all 8 lanes equal to a 32-bit sequence value S; tkeep = 32'hFFFFFFFF; S increments by 1 per beat, modulo 2^32, continuously across frames; tlast SHALL be on beat FRAME_BEATS-1 of each frame.
REQ-017 FSM SHALL have two states: HUNT and CHECK.
REQ-018 HUNT: the block SHALL ignore beats until a valid beat with tlast=1; it SHALL then load exp = lane0+1 and beat_idx = 0, and go to CHECK; no errors SHALL be counted in HUNT.
REQ-019 CHECK, per valid beat: the beat is errored if any lane differs from exp, if tkeep differs from all-ones, or if tlast differs from (beat_idx == FRAME_BEATS-1).
REQ-020 In CHECK, exp SHALL increment by 1 on every valid beat regardless of error; no resync to received data.
REQ-021 beat_idx SHALL reset to 0 on any beat with tlast=1 and otherwise increment; at FRAME_BEATS-1 without tlast it SHALL wrap to 0 and flag a length error.
REQ-022 frame_cnt SHALL increment on each tlast beat accepted in CHECK, errored or not.
REQ-023 Consecutive-error counter: increment on an errored beat, clear on a clean beat; on reaching LOSS_THRESH, go to HUNT in the same update.
REQ-024 Latency: all status outputs SHALL be registered and update on the clock edge that samples the beat (visible the cycle after tvalid); beat_err is high for exactly that one cycle.
REQ-025 axis_tvalid=0 cycles SHALL change no state (gaps allowed anywhere, including mid-frame).
REQ-026 When clr_cnt coincides with an errored beat, clr_cnt SHALL win: err_cnt=0, err_sticky=0, frame_cnt=0; beat_err still pulses; FSM and exp are unaffected by clr_cnt.

Reset
REQ-027 With axis_aresetn=0 at a clock edge: state=HUNT; lock, beat_err, err_sticky = 0; err_cnt, frame_cnt, exp, beat_idx, consecutive count = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL re-hunt on the next tlast beat.

Configuration
REQ-029 Macro DATA_RECV_CAPTURE_EN, when defined: outputs cap_data (256), cap_expect (32) and cap_valid (1) SHALL exist; on the first errored beat since reset or clr_cnt, they SHALL latch the received tdata and exp, and cap_valid SHALL be set; later errors SHALL not overwrite them; reset or clr_cnt SHALL zero all three.
REQ-030 Without DATA_RECV_CAPTURE_EN: these ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then 3 clean frames starting at S=0x00000000 with a leading tlast sync beat: after sync, lock=1; frame_cnt=3; err_cnt=0; err_sticky=0.
REQ-032 Corrupt lane 5 of beat 7 in frame 2: one beat_err pulse; err_cnt=1; lock stays 1; with capture enabled, cap_data lane5 = the corrupted value and cap_expect = the expected S.
REQ-033 Drop one beat mid-frame, with LOSS_THRESH=4: 4 consecutive errors, then lock=0 (HUNT); lock=1 again after the next tlast; err_cnt=4.
REQ-034 tkeep=32'h0000FFFF on one beat -> err_cnt+1; tlast on beat 10 of 16 -> length error counted; beat_idx=0 next.
REQ-035 Preload err_cnt to all-ones (ERR_CNT_W=4, 20 errors) -> err_cnt holds 4'hF; clr_cnt coinciding with an error -> err_cnt=0 next cycle, beat_err=1.
REQ-036 axis_aresetn=0 for 1 cycle mid-frame -> all outputs 0; re-lock on the following tlast; tvalid gaps of 0-5 cycles inserted randomly -> no errors.
